rmu_addr_ser: RTL and testbench
===============================

Name: rmu_addr_ser

Overview:
Upstream feeder for the RMU serial-address shift stage.
- Accepts parallel address words over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word MSB-first onto rmuadd, one bit per clk, with ale framing the bit window.
- The downstream stage shifts left every clock. After the last framed bit, its register therefore holds the original word.

Parameters:
WIDTH, 8, bits per address word and number of framed shift cycles.
DEPTH, 2, input FIFO entries (power of 2, >=2).
GAP, 1, idle cycles (ale=0, rmuadd=0) forced between consecutive words (0..15).

Ports:
clk  in  1  system clock, all state on rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  producer has a word on in_addr.
in_ready  out  1  FIFO can accept a word (= not full).
in_addr  in  WIDTH  parallel address word.
ps1  in  1  port-select enable; a new word may start only while ps1=1.
ale  out  1  high exactly while rmuadd carries a valid address bit.
rmuadd  out  1  serial address bit, MSB first.
busy  out  1  high in any state other than IDLE, or while FIFO not empty.
done  out  1  one-cycle pulse in the cycle after the last bit of a word.

Behaviour:
- Reset (async, active-high) values:
  - ale=0, rmuadd=0, done=0, busy=0, in_ready=1.
  - FIFO empty, FSM=IDLE, bit counter=0, gap counter=0.
  - Reset asserted mid-word aborts the word immediately. Outputs go to reset values asynchronously. FIFO contents are discarded.
- All outputs are registered (no combinational input-to-output path). Exception: in_ready, which is derived from the registered FIFO count.
- FIFO:
  - Push when in_valid & in_ready. Pop when the FSM loads.
  - Push and pop in the same cycle are allowed when not full; the count is unchanged.
  - When full, in_ready=0 and in_valid is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE -> SHIFT: when FIFO not empty and ps1=1 at a clock edge. The head word is popped into the shift register. ale=1 and rmuadd=word[WIDTH-1] appear after that edge.
  - SHIFT:
    - Each edge shifts the register left and increments the bit counter. ale stays 1.
    - After WIDTH bit-cycles, go to GAP when GAP>0, otherwise to IDLE.
    - On that edge ale->0, rmuadd->0, done->1 for one cycle.
    - ps1 is ignored during SHIFT: a started word always completes.
  - GAP: hold ale=0 for GAP cycles, then go to IDLE.
  - With GAP=0 and the FIFO non-empty with ps1=1 at the final shift edge: go directly to SHIFT with the next word. ale stays 1 continuously (back-to-back). done still pulses for one cycle.
- Latency: a word pushed at edge N with the FSM idle and ps1=1 loads at edge N+1. Its MSB is valid in the cycle after edge N+1. Its LSB is valid WIDTH-1 cycles later.
- ps1=0 while IDLE: words accumulate until the FIFO is full; no ale activity.
- The bit counter is ceil(log2(WIDTH+1)) bits wide and never wraps mid-word.

Optional Feature:
Macro RMU_ADDR_PARITY_EN.
- Defined:
  - Adds output rmupar (1 bit), equal to even parity (XOR) of the whole word.
  - rmupar is driven only in the last ale cycle of each word, 0 otherwise.
  - The parity bit is computed at load time and stored with the shift register.
- Not defined: port rmupar is absent. All other behaviour is identical.

Test Plan:
1. Reset, then push 0xA5 with ps1=1, GAP=1 -> ale high 8 cycles starting 2 cycles after push; rmuadd = 1,0,1,0,0,1,0,1; done pulses once; a downstream left-shift model captures 0xA5.
2. ps1=0, push 0x11, 0x22, 0x33 -> in_ready drops after the 2nd push (DEPTH=2); 0x33 is not accepted until ps1=1 and the first word loads; no ale activity while ps1=0.
3. GAP=0, push 0x0F and 0xF0 back-to-back with ps1=1 -> ale high for 16 continuous cycles; bit stream 00001111 11110000; done pulses twice.
4. Assert reset after the 3rd bit of 0xFF with one word queued -> ale, rmuadd, done go to 0 immediately; after release, busy=0 and the FIFO is empty.
5. Drop ps1 mid-word during 0x3C -> word completes all 8 bits; the next queued word waits until ps1=1.
6. With RMU_ADDR_PARITY_EN, send 0x07 then 0x03 -> rmupar=1 in the last bit cycle of 0x07, 0 in the last bit cycle of 0x03, and 0 elsewhere.

Source files
------------

// File: rtl/rmu_addr_ser.sv
// Parallel-to-serial address feeder for the RMU shift stage: FIFO-buffered words go out MSB-first on rmuadd, framed by ale.
// Optional RMU_ADDR_PARITY_EN adds rmupar, the word's XOR parity shown during its last framed bit.
module rmu_addr_ser #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_addr,
  input  logic             ps1,
  output logic             ale,
  output logic             rmuadd,
`ifdef RMU_ADDR_PARITY_EN
  output logic             rmupar,
`endif
  output logic             busy,
  output logic             done
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int BW   = $clog2(WIDTH + 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [3:0]      GAP_LEN  = 4'(GAP);
`ifdef RMU_ADDR_PARITY_EN
  localparam logic [BW-1:0]   PAR_BIT  = BW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q, count_d;
  logic             push, pop, load, last_edge, fifo_nonempty_d;
  logic [WIDTH-1:0] head;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic             ale_q, rmuadd_q, done_q, busy_q;
`ifdef RMU_ADDR_PARITY_EN
  logic             par_q, rmupar_q;
`endif

  assign in_ready        = (count_q != FULL_CNT);
  assign push            = in_valid & in_ready;
  assign head            = mem_q[rd_ptr_q];
  assign last_edge       = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
  // With no gap the next word may load on the final shift edge, keeping ale high.
  assign load            = (count_q != '0) && ps1 &&
                           ((state_q == ST_IDLE) || (last_edge && (GAP == 0)));
  assign pop             = load;
  assign count_d         = count_q + CNTW'(push) - CNTW'(pop);
  assign fifo_nonempty_d = (count_d != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      ale_q     <= 1'b0;
      rmuadd_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RMU_ADDR_PARITY_EN
      par_q     <= 1'b0;
      rmupar_q  <= 1'b0;
`endif
    end else begin
      done_q <= last_edge;
      if (load) begin
        state_q   <= ST_SHIFT;
        sr_q      <= head << 1;
        rmuadd_q  <= head[WIDTH-1];
        ale_q     <= 1'b1;
        bit_cnt_q <= BW'(1);
        busy_q    <= 1'b1;
`ifdef RMU_ADDR_PARITY_EN
        par_q     <= ^head;
        rmupar_q  <= (WIDTH == 1) ? ^head : 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: busy_q <= fifo_nonempty_d;
          ST_SHIFT: begin
            if (!last_edge) begin
              sr_q      <= sr_q << 1;
              rmuadd_q  <= sr_q[WIDTH-1];
              bit_cnt_q <= bit_cnt_q + BW'(1);
`ifdef RMU_ADDR_PARITY_EN
              rmupar_q  <= (bit_cnt_q == PAR_BIT) ? par_q : 1'b0;
`endif
            end else begin
              ale_q     <= 1'b0;
              rmuadd_q  <= 1'b0;
              bit_cnt_q <= '0;
`ifdef RMU_ADDR_PARITY_EN
              rmupar_q  <= 1'b0;
`endif
              if (GAP > 0) begin
                state_q   <= ST_GAP;
                gap_cnt_q <= 4'd1;
                busy_q    <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= fifo_nonempty_d;
              end
            end
          end
          ST_GAP: begin
            if (gap_cnt_q >= GAP_LEN) begin
              state_q   <= ST_IDLE;
              gap_cnt_q <= '0;
              busy_q    <= fifo_nonempty_d;
            end else begin
              gap_cnt_q <= gap_cnt_q + 4'd1;
              busy_q    <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= fifo_nonempty_d;
          end
        endcase
      end
    end
  end

  assign ale    = ale_q;
  assign rmuadd = rmuadd_q;
  assign done   = done_q;
  assign busy   = busy_q;
`ifdef RMU_ADDR_PARITY_EN
  assign rmupar = rmupar_q;
`endif

endmodule

// File: tb/tb_rmu_addr_ser.sv
// Directed bench for rmu_addr_ser: one instance with GAP=1 and one with GAP=0 for back-to-back framing.
module tb_rmu_addr_ser;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, ps1, ale, rmuadd, busy, done;
  logic [7:0] in_addr;
  logic       in_valid0, in_ready0, ps1_0, ale0, rmuadd0, busy0, done0;
  logic [7:0] in_addr0;
`ifdef RMU_ADDR_PARITY_EN
  logic       rmupar, rmupar0;
`endif

  always #5 clk = ~clk;

  rmu_addr_ser #(.WIDTH(8), .DEPTH(2), .GAP(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .ps1(ps1), .ale(ale), .rmuadd(rmuadd),
`ifdef RMU_ADDR_PARITY_EN
    .rmupar(rmupar),
`endif
    .busy(busy), .done(done)
  );

  rmu_addr_ser #(.WIDTH(8), .DEPTH(2), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_addr(in_addr0), .ps1(ps1_0), .ale(ale0), .rmuadd(rmuadd0),
`ifdef RMU_ADDR_PARITY_EN
    .rmupar(rmupar0),
`endif
    .busy(busy0), .done(done0)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ale_cnt, done_cnt, ale0_cnt, done0_cnt, run0, max_run0;
  int          widx, par_ones, waited;
  logic [31:0] stream, stream0;
  logic [7:0]  cap, par_log;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic mon_clr();
    ale_cnt = 0; done_cnt = 0; ale0_cnt = 0; done0_cnt = 0; run0 = 0; max_run0 = 0;
    widx = 0; par_ones = 0; stream = '0; stream0 = '0; cap = '0; par_log = '0;
  endtask

  // Advance one clock and sample at the falling edge; cap models the downstream left-shift register.
  task automatic step();
    @(negedge clk);
    if (ale) begin
      stream = {stream[30:0], rmuadd};
      cap    = {cap[6:0], rmuadd};
      ale_cnt++;
    end
    if (done) done_cnt++;
    if (ale0) begin
      stream0 = {stream0[30:0], rmuadd0};
      ale0_cnt++;
      run0++;
      if (run0 > max_run0) max_run0 = run0;
    end else run0 = 0;
    if (done0) done0_cnt++;
`ifdef RMU_ADDR_PARITY_EN
    if (ale) widx++; else widx = 0;
    if (rmupar) par_ones++;
    if (ale && widx == 8) par_log = {par_log[6:0], rmupar};
`endif
  endtask

  task automatic push(input logic [7:0] a);
    in_valid = 1'b1; in_addr = a;
    step();
    in_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [7:0] a, input int max, output int w);
    in_valid = 1'b1; in_addr = a; w = 0;
    while (!in_ready && w < max) begin step(); w++; end
    if (in_ready) step();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; ps1 = 1'b0;
    in_valid0 = 1'b0; in_addr0 = '0; ps1_0 = 1'b0;
    mon_clr();
    step(); step();
    check_eq("rst_ale", 32'(ale), 32'd0);
    check_eq("rst_rmuadd", 32'(rmuadd), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_in_ready0", 32'(in_ready0), 32'd1);
    reset = 1'b0;

    // 1: single word 0xA5, GAP=1
    mon_clr(); ps1 = 1'b1;
    push(8'hA5);
    check_eq("t1_ale_after_push", 32'(ale), 32'd0);
    check_eq("t1_busy_after_push", 32'(busy), 32'd1);
    step();
    check_eq("t1_ale_first", 32'(ale), 32'd1);
    check_eq("t1_msb", 32'(rmuadd), 32'd1);
    repeat (7) step();
    check_eq("t1_ale_last", 32'(ale), 32'd1);
    check_eq("t1_lsb", 32'(rmuadd), 32'd1);
    step();
    check_eq("t1_ale_end", 32'(ale), 32'd0);
    check_eq("t1_done_pulse", 32'(done), 32'd1);
    repeat (4) step();
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t1_ale_cnt", 32'(ale_cnt), 32'd8);
    check_eq("t1_capture", 32'(cap), 32'hA5);
    check_eq("t1_busy_idle", 32'(busy), 32'd0);

    // 2: ps1 low, FIFO fills, third word waits for the first load
    mon_clr(); ps1 = 1'b0;
    push(8'h11);
    push(8'h22);
    check_eq("t2_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_addr = 8'h33;
    repeat (4) step();
    check_eq("t2_hold_ready", 32'(in_ready), 32'd0);
    check_eq("t2_no_ale", 32'(ale_cnt), 32'd0);
    check_eq("t2_busy_queued", 32'(busy), 32'd1);
    ps1 = 1'b1;
    push_wait(8'h33, 20, waited);
    check_eq("t2_accept_wait", 32'(waited), 32'd1);
    repeat (40) step();
    check_eq("t2_ale_cnt", 32'(ale_cnt), 32'd24);
    check_eq("t2_stream", stream & 32'h00FF_FFFF, 32'h0011_2233);
    check_eq("t2_done_cnt", 32'(done_cnt), 32'd3);
    check_eq("t2_busy_idle", 32'(busy), 32'd0);

    // 3: GAP=0 back-to-back on dut0
    mon_clr(); ps1_0 = 1'b1;
    in_valid0 = 1'b1; in_addr0 = 8'h0F;
    step();
    in_addr0 = 8'hF0;
    step();
    in_valid0 = 1'b0;
    repeat (20) step();
    check_eq("t3_ale_cnt", 32'(ale0_cnt), 32'd16);
    check_eq("t3_ale_run", 32'(max_run0), 32'd16);
    check_eq("t3_stream", stream0 & 32'h0000_FFFF, 32'h0000_0FF0);
    check_eq("t3_done_cnt", 32'(done0_cnt), 32'd2);
    check_eq("t3_busy_idle", 32'(busy0), 32'd0);

    // 4: async reset mid-word with a word queued
    mon_clr(); ps1 = 1'b1;
    push(8'hFF);
    in_valid = 1'b1; in_addr = 8'h5A;
    step();
    in_valid = 1'b0;
    step(); step();
    check_eq("t4_ale_bit3", 32'(ale), 32'd1);
    check_eq("t4_rmuadd_bit3", 32'(rmuadd), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t4_async_ale", 32'(ale), 32'd0);
    check_eq("t4_async_rmuadd", 32'(rmuadd), 32'd0);
    check_eq("t4_async_done", 32'(done), 32'd0);
    check_eq("t4_async_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    mon_clr();
    repeat (12) step();
    check_eq("t4_fifo_flushed", 32'(ale_cnt), 32'd0);
    check_eq("t4_busy_after", 32'(busy), 32'd0);
    check_eq("t4_ready_after", 32'(in_ready), 32'd1);

    // 5: ps1 dropped mid-word
    mon_clr(); ps1 = 1'b1;
    push(8'h3C);
    in_valid = 1'b1; in_addr = 8'h81;
    step();
    in_valid = 1'b0;
    step(); step();
    ps1 = 1'b0;
    repeat (16) step();
    check_eq("t5_ale_cnt", 32'(ale_cnt), 32'd8);
    check_eq("t5_capture", 32'(cap), 32'h3C);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t5_busy_waiting", 32'(busy), 32'd1);
    ps1 = 1'b1;
    repeat (14) step();
    check_eq("t5_ale_cnt2", 32'(ale_cnt), 32'd16);
    check_eq("t5_capture2", 32'(cap), 32'h81);
    check_eq("t5_busy_idle", 32'(busy), 32'd0);

`ifdef RMU_ADDR_PARITY_EN
    // 6: parity on the last framed bit
    mon_clr(); ps1 = 1'b1;
    push(8'h07);
    in_valid = 1'b1; in_addr = 8'h03;
    step();
    in_valid = 1'b0;
    repeat (25) step();
    check_eq("t6_par_ones", 32'(par_ones), 32'd1);
    check_eq("t6_par_last", 32'(par_log[1:0]), 32'd2);
    check_eq("t6_capture", 32'(cap), 32'h03);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
